// File: rtl/instr_mem_ctrl.sv
// Writable instruction memory with a registered, stall/flush-aware fetch port.
// Self-clears to NOP after reset, takes a program through the load port, then serves fetches.
module instr_mem_ctrl #(
   parameter int unsigned N     = 32,
   parameter int unsigned DEPTH = 64,
   parameter int unsigned PC_W  = 32,
   parameter logic [N-1:0] NOP  = '0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     prog_we,
   input  logic [$clog2(DEPTH)-1:0] prog_addr,
   input  logic [N-1:0]             prog_data,
   input  logic                     prog_done,
   input  logic                     prog_enter,
   input  logic [PC_W-1:0]          pc,
   input  logic                     fetch_req,
   input  logic                     stall,
   input  logic                     flush,
   output logic [N-1:0]             instr,
   output logic                     instr_valid,
   output logic                     fetch_fault,
   output logic                     ready,
   output logic                     prog_err
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned IW = PC_W - 2;

   typedef enum logic [1:0] {S_CLEAR, S_PROG, S_RUN} state_t;

   state_t         state_q, state_d;
   logic [AW-1:0]  clr_cnt_q, clr_cnt_d;
   logic [N-1:0]   instr_q, instr_d;
   logic           valid_q, valid_d;
   logic           fault_q, fault_d;
   logic           ready_q, ready_d;
   logic           err_q, err_d;

   logic [N-1:0]   mem [DEPTH];
   logic           mem_we;
   logic [AW-1:0]  mem_waddr;
   logic [N-1:0]   mem_wdata;

   logic           addr_ok;
   logic           pc_fault;
   logic [IW-1:0]  word_idx;
   logic [N-1:0]   rd_data;

   // Zero-extended compares keep power-of-two DEPTH from truncating to zero
   assign addr_ok  = {1'b0, prog_addr} < (AW+1)'(DEPTH);
   assign word_idx = pc[PC_W-1:2];
   assign pc_fault = (pc[1:0] != 2'b00) || (word_idx >= IW'(DEPTH));
   assign rd_data  = mem[word_idx[AW-1:0]];

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      instr_d   = instr_q;
      valid_d   = valid_q;
      fault_d   = fault_q;
      err_d     = err_q;
      mem_we    = 1'b0;
      mem_waddr = clr_cnt_q;
      mem_wdata = NOP;

      unique case (state_q)
         S_CLEAR: begin
            mem_we = 1'b1;
            if (clr_cnt_q == AW'(DEPTH - 1)) begin
               state_d   = S_PROG;
               clr_cnt_d = '0;
            end else begin
               clr_cnt_d = clr_cnt_q + AW'(1);
            end
         end
         S_PROG: begin
            if (prog_we) begin
               if (addr_ok) begin
                  mem_we    = 1'b1;
                  mem_waddr = prog_addr;
                  mem_wdata = prog_data;
               end else begin
                  err_d = 1'b1;
               end
            end
            if (prog_done) state_d = S_RUN;
         end
         S_RUN: begin
            if (prog_we)    err_d   = 1'b1;
            if (prog_enter) state_d = S_PROG;
         end
         default: state_d = S_CLEAR;
      endcase

      // Fetch result: flush wins, then leaving RUN, then stall hold, then a fetch
      if (flush) begin
         instr_d = NOP;
         valid_d = 1'b0;
         fault_d = 1'b0;
      end else if (state_q != S_RUN || prog_enter) begin
         valid_d = 1'b0;
         fault_d = 1'b0;
      end else if (!stall) begin
         if (fetch_req) begin
            instr_d = pc_fault ? NOP : rd_data;
            valid_d = 1'b1;
            fault_d = pc_fault;
         end else begin
            valid_d = 1'b0;
            fault_d = 1'b0;
         end
      end
   end

   assign ready_d = (state_d == S_RUN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_CLEAR;
         clr_cnt_q <= '0;
         instr_q   <= NOP;
         valid_q   <= 1'b0;
         fault_q   <= 1'b0;
         ready_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         instr_q   <= instr_d;
         valid_q   <= valid_d;
         fault_q   <= fault_d;
         ready_q   <= ready_d;
         err_q     <= err_d;
      end
   end

   // Storage array carries no reset; the CLEAR sweep initialises it
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   assign instr       = instr_q;
   assign instr_valid = valid_q;
   assign fetch_fault = fault_q;
   assign ready       = ready_q;
   assign prog_err    = err_q;

endmodule
